// File: rtl/qlearn_pkg.sv
// qlearn_pkg: shared widths, FSM state encoding, issue payload and the
// action LFSR step used by the Q-learning episode scheduler.
package qlearn_pkg;

  localparam int STATE_W  = 6;
  localparam int ACTION_W = 2;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [STATE_W-1:0]  s;
    logic [ACTION_W-1:0] a;
    logic [STATE_W-1:0]  ns;
  } issue_t;

  // One step of the action LFSR; a zero state would lock up, so seeds must be nonzero
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/qlearn_episode_ctrl_if.sv
// qlearn_episode_ctrl_if: link between the episode scheduler (master) and the
// update pipeline / next-state ROM side (slave).
interface qlearn_episode_ctrl_if;
  import qlearn_pkg::*;

  logic [STATE_W+ACTION_W-1:0] ns_addr;
  logic [STATE_W-1:0]          ns_data;
  logic                        issue_valid;
  logic                        issue_ready;
  logic [STATE_W-1:0]          issue_s;
  logic [ACTION_W-1:0]         issue_a;
  logic [STATE_W-1:0]          issue_ns;
  logic                        retire;

  modport master (
    output ns_addr, issue_valid, issue_s, issue_a, issue_ns,
    input  ns_data, issue_ready, retire
  );

  modport slave (
    input  ns_addr, issue_valid, issue_s, issue_a, issue_ns,
    output ns_data, issue_ready, retire
  );

endinterface

// File: rtl/qlearn_scoreboard.sv
// qlearn_scoreboard: in-order FIFO of states whose Qmax write is still in
// flight, with a parallel compare of one state against every valid entry.
module qlearn_scoreboard
  import qlearn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [STATE_W-1:0] i_push_state,
  input  logic               i_pop,
  input  logic [STATE_W-1:0] i_match_state,
  output logic               o_match,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [STATE_W-1:0] entry [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (count == CNT_W'(DEPTH));
  assign o_empty = (count == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Entry payload storage; only the valid bits need a reset value
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      entry[wr_ptr] <= i_push_state;
    end
  end

  // Pointers, occupancy and valid bits; push and pop together keep occupancy
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr      <= ptr_inc(wr_ptr);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        vld[rd_ptr] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Any valid entry equal to the probe state means a pending Qmax write to it
  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (entry[i] == i_match_state)) begin
        o_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qlearn_episode_ctrl.sv
// qlearn_episode_ctrl: runs Q-learning episodes, drawing actions from an LFSR,
// reading the next-state ROM and issuing {s, a, ns} updates to the pipeline.
// Optional feature macro: QLEARN_CTRL_HAZARD_EN enables the stall that keeps a
// Qmax read of state ns from overtaking a pending Qmax write to ns.
module qlearn_episode_ctrl
  import qlearn_pkg::*;
#(
  parameter int          PIPE_DEPTH = 4,
  parameter int          STEP_W     = 8,
  parameter int          EP_W       = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [STATE_W-1:0]    i_start_state,
  input  logic [STATE_W-1:0]    i_end_state,
  input  logic [STEP_W-1:0]     i_max_steps,
  input  logic [EP_W-1:0]       i_num_episodes,
  qlearn_episode_ctrl_if.master pipe,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [EP_W-1:0]       o_episode_cnt,
  output logic [STEP_W-1:0]     o_step_cnt,
  output logic                  o_err
);

  state_t             state;
  issue_t             pay;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_adv;
  logic [STATE_W-1:0] start_q;
  logic [STATE_W-1:0] end_q;
  logic [STEP_W-1:0]  max_q;
  logic [EP_W-1:0]    num_q;
  logic [STEP_W-1:0]  step_inc;
  logic [EP_W-1:0]    ep_inc;
  logic               sb_full;
  logic               sb_empty;
  logic               sb_match;
  logic               hazard;
  logic               issue_valid;
  logic               issue_fire;
  logic               last_step;

  qlearn_scoreboard #(
    .DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (issue_fire),
    .i_push_state  (pay.s),
    .i_pop         (pipe.retire),
    .i_match_state (pay.ns),
    .o_match       (sb_match),
    .o_full        (sb_full),
    .o_empty       (sb_empty)
  );

`ifdef QLEARN_CTRL_HAZARD_EN
  assign hazard = sb_match;
`else
  logic unused_match;
  assign unused_match = sb_match;
  assign hazard       = 1'b0;
`endif

  assign lfsr_adv    = lfsr_step(lfsr);
  assign step_inc    = o_step_cnt + 1'b1;
  assign ep_inc      = o_episode_cnt + 1'b1;
  assign issue_valid = (state == ST_ISSUE) && !sb_full && !hazard;
  assign issue_fire  = issue_valid && pipe.issue_ready;
  assign last_step   = (pay.ns == end_q) ||
                       ((max_q != '0) && (step_inc == max_q));

  assign pipe.ns_addr     = {pay.s, pay.a};
  assign pipe.issue_valid = issue_valid;
  assign pipe.issue_s     = pay.s;
  assign pipe.issue_a     = pay.a;
  assign pipe.issue_ns    = pay.ns;
  assign o_busy           = (state != ST_IDLE);

  // Episode FSM; every entry into SELECT advances the LFSR and picks the action
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      pay           <= '0;
      lfsr          <= LFSR_SEED;
      start_q       <= '0;
      end_q         <= '0;
      max_q         <= '0;
      num_q         <= '0;
      o_step_cnt    <= '0;
      o_episode_cnt <= '0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (pipe.retire && sb_empty) begin
        o_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            start_q       <= i_start_state;
            end_q         <= i_end_state;
            max_q         <= i_max_steps;
            num_q         <= i_num_episodes;
            o_step_cnt    <= '0;
            o_episode_cnt <= '0;
            if (i_num_episodes == '0) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              pay.s <= i_start_state;
              pay.a <= lfsr_adv[ACTION_W-1:0];
              lfsr  <= lfsr_adv;
              state <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          pay.ns <= pipe.ns_data;
          state  <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (issue_fire) begin
            o_step_cnt <= step_inc;
            pay.s      <= pay.ns;
            if (last_step) begin
              state <= ST_DRAIN;
            end else begin
              pay.a <= lfsr_adv[ACTION_W-1:0];
              lfsr  <= lfsr_adv;
              state <= ST_SELECT;
            end
          end
        end
        ST_DRAIN: begin
          if (sb_empty) begin
            o_episode_cnt <= ep_inc;
            if (ep_inc == num_q) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              pay.s      <= start_q;
              pay.a      <= lfsr_adv[ACTION_W-1:0];
              lfsr       <= lfsr_adv;
              o_step_cnt <= '0;
              state      <= ST_SELECT;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// tb_qlearn_episode_ctrl: directed bench for the episode scheduler. A table of
// episode configurations runs with a 4-cycle retire model, followed by
// hand-written sequences for hazard stalls, scoreboard-full, backpressure,
// zero episodes, mid-episode reset and the sticky error flag.
// Expectations follow the QLEARN_CTRL_HAZARD_EN setting of the build.
module tb_qlearn_episode_ctrl;
  import qlearn_pkg::*;

  typedef struct {
    logic [5:0]  start_s;
    logic [5:0]  end_s;
    logic [7:0]  max_steps;
    logic [15:0] num_eps;
    bit          self5;
    int          exp_issues;
    int          exp_eps;
    int          exp_steps;
    int          exp_last_s;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [5:0]  i_start_state;
  logic [5:0]  i_end_state;
  logic [7:0]  i_max_steps;
  logic [15:0] i_num_episodes;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_episode_cnt;
  logic [7:0]  o_step_cnt;
  logic        o_err;

  bit          self5;
  bit          auto_retire;
  logic [3:0]  dl;
  int          checks;
  int          failures;
  int          issue_cnt;
  int          done_seen;
  logic [5:0]  log_s [$];
  logic [1:0]  log_a [$];

  always #5 i_clk = ~i_clk;

  // Next-state ROM model: s+1, optionally with a self-loop at state 5
  function automatic logic [5:0] rom(input logic [7:0] addr, input bit loop5);
    logic [5:0] s;
    s = addr[7:2];
    if (loop5 && (s == 6'd5)) return 6'd5;
    return s + 6'd1;
  endfunction

  function automatic logic [15:0] model_lfsr(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  qlearn_episode_ctrl_if bus ();
  assign bus.ns_data = rom(bus.ns_addr, self5);

  qlearn_episode_ctrl #(
    .PIPE_DEPTH (4),
    .STEP_W     (8),
    .EP_W       (16),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_start_state  (i_start_state),
    .i_end_state    (i_end_state),
    .i_max_steps    (i_max_steps),
    .i_num_episodes (i_num_episodes),
    .pipe           (bus),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_episode_cnt  (o_episode_cnt),
    .o_step_cnt     (o_step_cnt),
    .o_err          (o_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: log a handshake, advance the retire delay line, count done pulses
  task automatic tick();
    logic fire;
    fire = bus.issue_valid && bus.issue_ready;
    if (fire) begin
      issue_cnt++;
      log_s.push_back(bus.issue_s);
      log_a.push_back(bus.issue_a);
    end
    @(posedge i_clk);
    #1;
    dl = {dl[2:0], fire};
    if (auto_retire) bus.retire = dl[3];
    if (o_done) done_seen++;
  endtask

  task automatic doReset();
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    bus.retire = 1'b0;
    dl         = '0;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [5:0] st, input logic [5:0] en, input logic [7:0] mx,
                               input logic [15:0] ne, input bit loop5);
    i_start_state  = st;
    i_end_state    = en;
    i_max_steps    = mx;
    i_num_episodes = ne;
    self5          = loop5;
    issue_cnt      = 0;
    done_seen      = 0;
    log_s.delete();
    log_a.delete();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  vec_t       vecs [6];
  bit         rp [14];
  bit         vp [14];
  bit         dp [14];
  logic [1:0] run1_a [4];
  logic [15:0] mx;

  initial begin
    checks          = 0;
    failures        = 0;
    issue_cnt       = 0;
    done_seen       = 0;
    auto_retire     = 1'b0;
    self5           = 1'b0;
    dl              = '0;
    i_start_state   = '0;
    i_end_state     = '0;
    i_max_steps     = '0;
    i_num_episodes  = '0;
    bus.issue_ready = 1'b1;
    bus.retire      = 1'b0;

    vecs[0] = '{6'd0,  6'd3,  8'd0, 16'd1, 1'b0, 3, 1, 3, 2};
    vecs[1] = '{6'd9,  6'd12, 8'd0, 16'd0, 1'b0, 0, 0, 0, 0};
    vecs[2] = '{6'd0,  6'd3,  8'd0, 16'd2, 1'b0, 6, 2, 3, 2};
    vecs[3] = '{6'd5,  6'd5,  8'd0, 16'd1, 1'b1, 1, 1, 1, 5};
    vecs[4] = '{6'd10, 6'd63, 8'd5, 16'd1, 1'b0, 5, 1, 5, 14};
    vecs[5] = '{6'd20, 6'd22, 8'd0, 16'd3, 1'b0, 6, 3, 2, 21};

    // Reset state
    doReset();
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_ep_cnt", o_episode_cnt, 0);
    checkOutput("rst_step_cnt", o_step_cnt, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_valid", bus.issue_valid, 0);
    checkOutput("rst_ns_addr", bus.ns_addr, 0);
    checkOutput("rst_payload", {bus.issue_s, bus.issue_a, bus.issue_ns}, 0);

    // Table of complete runs with the retire model active
    auto_retire = 1'b1;
    bus.issue_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].start_s, vecs[v].end_s, vecs[v].max_steps, vecs[v].num_eps, vecs[v].self5);
      for (int c = 0; c < 400 && done_seen == 0; c++) tick();
      tick();
      tick();
      checkOutput($sformatf("v%0d_done_pulses", v), done_seen, 1);
      checkOutput($sformatf("v%0d_issues", v), issue_cnt, vecs[v].exp_issues);
      checkOutput($sformatf("v%0d_ep_cnt", v), o_episode_cnt, vecs[v].exp_eps);
      checkOutput($sformatf("v%0d_step_cnt", v), o_step_cnt, vecs[v].exp_steps);
      checkOutput($sformatf("v%0d_busy", v), o_busy, 0);
      if (vecs[v].exp_issues > 0 && log_s.size() > 0)
        checkOutput($sformatf("v%0d_last_s", v), log_s[log_s.size()-1], vecs[v].exp_last_s);
    end
    checkOutput("table_err", o_err, 0);

    // Zero episodes: done one cycle after start, no issues
    applyStimulus(6'd1, 6'd2, 8'd0, 16'd0, 1'b0);
    checkOutput("zero_ep_done", o_done, 1);
    checkOutput("zero_ep_busy", o_busy, 1);
    tick();
    checkOutput("zero_ep_done_end", o_done, 0);
    checkOutput("zero_ep_idle", o_busy, 0);
    checkOutput("zero_ep_issues", issue_cnt, 0);

    // Backpressure: payload {0, a=0, 1} must hold while ready is low
    doReset();
    bus.issue_ready = 1'b0;
    applyStimulus(6'd0, 6'd3, 8'd0, 16'd1, 1'b0);
    checkOutput("bp_select_valid", bus.issue_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_valid_%0d", i), bus.issue_valid, 1);
      checkOutput($sformatf("bp_payload_%0d", i), {bus.issue_s, bus.issue_a, bus.issue_ns}, {6'd0, 2'd0, 6'd1});
      checkOutput($sformatf("bp_step_%0d", i), o_step_cnt, 0);
      tick();
    end
    bus.issue_ready = 1'b1;
    tick();
    checkOutput("bp_step_after", o_step_cnt, 1);
    checkOutput("bp_valid_after", bus.issue_valid, 0);
    for (int c = 0; c < 100 && done_seen == 0; c++) tick();
    checkOutput("bp_issues", issue_cnt, 3);

    // Scoreboard full: no retires, chain 0->1->..., exactly 4 issues
    doReset();
    auto_retire = 1'b0;
    applyStimulus(6'd0, 6'd63, 8'd0, 16'd1, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    checkOutput("full_issues", issue_cnt, 4);
    checkOutput("full_valid", bus.issue_valid, 0);
    checkOutput("full_busy", o_busy, 1);
    checkOutput("full_step", o_step_cnt, 4);
    doReset();

    // Hazard: self-loop at state 5, retires scripted per cycle
    for (int i = 0; i < 14; i++) begin
      rp[i] = 1'b0;
      vp[i] = 1'b0;
      dp[i] = 1'b0;
    end
`ifdef QLEARN_CTRL_HAZARD_EN
    vp[1] = 1'b1; vp[6] = 1'b1; vp[9] = 1'b1;
    rp[5] = 1'b1; rp[8] = 1'b1; rp[10] = 1'b1;
    dp[12] = 1'b1;
`else
    vp[1] = 1'b1; vp[3] = 1'b1; vp[5] = 1'b1;
    rp[6] = 1'b1; rp[7] = 1'b1; rp[8] = 1'b1;
    dp[10] = 1'b1;
`endif
    applyStimulus(6'd5, 6'd63, 8'd3, 16'd1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      bus.retire = rp[i];
      checkOutput($sformatf("haz_valid_c%0d", i + 1), bus.issue_valid, vp[i]);
      checkOutput($sformatf("haz_done_c%0d", i + 1), o_done, dp[i]);
      tick();
    end
    bus.retire = 1'b0;
    checkOutput("haz_issues", issue_cnt, 3);
    checkOutput("haz_ep_cnt", o_episode_cnt, 1);
    checkOutput("haz_step_cnt", o_step_cnt, 3);
    checkOutput("haz_err", o_err, 0);
    foreach (log_s[k]) checkOutput($sformatf("haz_s_%0d", k), log_s[k], 5);

    // Reset during episode 2 of 3, then a fresh run repeats the action sequence
    doReset();
    auto_retire = 1'b1;
    applyStimulus(6'd0, 6'd3, 8'd0, 16'd3, 1'b0);
    for (int c = 0; c < 100 && issue_cnt < 4; c++) tick();
    checkOutput("mid_issues", issue_cnt, 4);
    checkOutput("mid_ep_cnt", o_episode_cnt, 1);
    for (int k = 0; k < 4; k++) run1_a[k] = (k < log_a.size()) ? log_a[k] : 2'bxx;
    i_rst_n    = 1'b0;
    bus.retire = 1'b0;
    dl         = '0;
    @(posedge i_clk);
    #1;
    checkOutput("mid_rst_busy", o_busy, 0);
    checkOutput("mid_rst_valid", bus.issue_valid, 0);
    checkOutput("mid_rst_ep", o_episode_cnt, 0);
    checkOutput("mid_rst_step", o_step_cnt, 0);
    checkOutput("mid_rst_addr", bus.ns_addr, 0);
    i_rst_n = 1'b1;
    applyStimulus(6'd0, 6'd3, 8'd0, 16'd3, 1'b0);
    for (int c = 0; c < 200 && done_seen == 0; c++) tick();
    checkOutput("rerun_issues", issue_cnt, 9);
    checkOutput("rerun_ep_cnt", o_episode_cnt, 3);
    mx = 16'hACE1;
    for (int k = 0; k < 9; k++) begin
      mx = model_lfsr(mx);
      if (k < log_a.size()) checkOutput($sformatf("rerun_a_%0d", k), log_a[k], mx[1:0]);
      if (k < 4 && k < log_a.size()) checkOutput($sformatf("repeat_a_%0d", k), log_a[k], run1_a[k]);
    end
    tick();
    tick();

    // Spurious retire while idle sets a sticky error that only reset clears
    auto_retire = 1'b0;
    checkOutput("err_before", o_err, 0);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    checkOutput("err_set", o_err, 1);
    tick();
    tick();
    tick();
    checkOutput("err_sticky", o_err, 1);
    doReset();
    checkOutput("err_cleared", o_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
